serial2tcp_tx_arbiter: RTL and testbench

SERIAL2TCP_TX_ARBITER -- requirements
Module: serial2tcp_tx_arbiter

---
 rtl/serial2tcp_pkg.sv | 20 ++
 rtl/serial2tcp_rr_pick.sv | 44 ++++
 rtl/serial2tcp_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_serial2tcp_tx_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial2tcp_pkg.sv
// Shared definitions for the serial-to-TCP transmit arbiter.
// Holds the FSM state encoding (identical with and without SERIAL2TCP_ARB_TAG_EN)
// and the tag-byte helper used when tagging is enabled.
package serial2tcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Only the low two bits of the tag carry the requester index.
    localparam logic [1:0] TAG_LOW_MASK = 2'b11;

    // Builds the tag byte announcing which requester owns the following burst.
    function automatic logic [7:0] make_tag(input logic [7:0] base, input logic [1:0] id);
        return base | {6'b000000, id & TAG_LOW_MASK};
    endfunction

endpackage

// File: rtl/serial2tcp_rr_pick.sv
// Round-robin requester selector: searches from last+1 upward, wrapping at
// NUM_REQ, and reports the first requester with valid high.
module serial2tcp_rr_pick
    import serial2tcp_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         last,
    output logic [1:0]         next,
    output logic               any
);

    logic [3:0] valid_pad_s;
    logic [2:0] sum_s;
    logic [1:0] idx_s;

    assign valid_pad_s = 4'(valid);

    // Walk candidates farthest-first so the nearest valid one after last wins.
    always_comb begin
        next  = last;
        any   = 1'b0;
        sum_s = 3'd0;
        idx_s = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum_s = {1'b0, last} + 3'(k);
            if (sum_s >= 3'(NUM_REQ)) begin
                sum_s = sum_s - 3'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[1:0];
            if (valid_pad_s[idx_s]) begin
                next = idx_s;
                any  = 1'b1;
            end else begin
                next = next;
                any  = any;
            end
        end
    end

endmodule

// File: rtl/serial2tcp_tx_arbiter.sv
// Serial-to-TCP transmit arbiter: grants one byte-stream requester at a time
// (round-robin, up to MAX_BURST bytes per grant) and forwards its bytes through
// a single registered output stage to the TCP bridge.
// Optional feature: define SERIAL2TCP_ARB_TAG_EN to prefix each burst with a
// tag byte TAG_BASE | grant_id.
module serial2tcp_tx_arbiter
    import serial2tcp_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] TAG_BASE  = 8'hF0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic                 serial2tcp_source_valid,
    input  logic                 serial2tcp_source_ready,
    output logic [7:0]           serial2tcp_source_data,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    arb_state_t state_r;
    logic [1:0] grant_id_r;
    logic [7:0] burst_r;
    logic       src_valid_r;
    logic [7:0] src_data_r;
    logic       busy_r;

    logic       load_ok_s;
    logic [1:0] pick_s;
    logic       any_s;
    logic [3:0] valid_pad_s;
    logic [31:0] data_pad_s;
    logic       sel_valid_s;
    logic [7:0] sel_byte_s;
    logic [3:0] ready_pad_s;

    serial2tcp_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (req_valid),
        .last  (grant_id_r),
        .next  (pick_s),
        .any   (any_s)
    );

    assign load_ok_s   = !src_valid_r || serial2tcp_source_ready;
    assign valid_pad_s = 4'(req_valid);
    assign data_pad_s  = 32'(req_data);
    assign sel_valid_s = valid_pad_s[grant_id_r];
    assign sel_byte_s  = data_pad_s[{grant_id_r, 3'b000} +: 8];
    assign ready_pad_s = ((state_r == ST_DATA) && load_ok_s) ? (4'b0001 << grant_id_r) : 4'b0000;

    assign req_ready               = ready_pad_s[NUM_REQ-1:0];
    assign serial2tcp_source_valid = src_valid_r;
    assign serial2tcp_source_data  = src_data_r;
    assign grant_id                = grant_id_r;
    assign busy                    = busy_r;

    // Arbitration FSM together with the output register and burst counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            grant_id_r  <= 2'(NUM_REQ - 1);
            burst_r     <= 8'd0;
            src_valid_r <= 1'b0;
            src_data_r  <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Drain any byte still held from the previous grant.
                    if (load_ok_s) begin
                        src_valid_r <= 1'b0;
                    end
                    if (any_s) begin
                        grant_id_r <= pick_s;
                        burst_r    <= 8'd0;
                        busy_r     <= 1'b1;
`ifdef SERIAL2TCP_ARB_TAG_EN
                        state_r    <= ST_TAG;
`else
                        state_r    <= ST_DATA;
`endif
                    end
                end
                ST_TAG: begin
                    // Tag byte does not count against the burst.
                    if (load_ok_s) begin
                        src_data_r  <= make_tag(TAG_BASE, grant_id_r);
                        src_valid_r <= 1'b1;
                        state_r     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (load_ok_s) begin
                        if (sel_valid_s) begin
                            src_data_r  <= sel_byte_s;
                            src_valid_r <= 1'b1;
                            burst_r     <= burst_r + 8'd1;
                            if ((burst_r + 8'd1) == 8'(MAX_BURST)) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            // Requester released its stream.
                            src_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    src_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial2tcp_tx_arbiter.sv
// Directed bench for serial2tcp_tx_arbiter (NUM_REQ=2, MAX_BURST=4).
// Requester i emits a deterministic byte sequence; the sink records every
// accepted output byte for order checks.
module tb_serial2tcp_tx_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int MAX_BURST = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data;
    logic        src_valid;
    logic        src_ready;
    logic [7:0]  src_data;
    logic [1:0]  grant_id;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cnt [2];
    int          lim [2];
    logic        sink_ready;
    logic [7:0]  cap_q [$];

    serial2tcp_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .TAG_BASE  (8'hF0)
    ) dut (
        .sys_clk                 (sys_clk),
        .sys_rst                 (sys_rst),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_data                (req_data),
        .serial2tcp_source_valid (src_valid),
        .serial2tcp_source_ready (src_ready),
        .serial2tcp_source_data  (src_data),
        .grant_id                (grant_id),
        .busy                    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester 0 sends 0x11,0x22,0x33,...; requester 1 sends 0xAA,0xAB,...
    function automatic logic [7:0] byte_of(input int i, input int c);
        if (i == 0) return 8'((c + 1) * 17);
        else        return 8'(170 + c);
    endfunction

    // One clock: drive inputs at negedge, note handshakes, return at posedge+1.
    task automatic cycle();
        logic [1:0] hs;
        logic       sh;
        logic [7:0] sd;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            req_valid[i]         = (cnt[i] < lim[i]);
            req_data[8*i +: 8]   = byte_of(i, cnt[i]);
        end
        src_ready = sink_ready;
        #1;
        hs = req_valid & req_ready;
        sh = src_valid && src_ready;
        sd = src_data;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) cnt[i]++;
        end
        if (sh) cap_q.push_back(sd);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst    = 1'b1;
        req_valid  = 2'b00;
        cnt[0] = 0; cnt[1] = 0; lim[0] = 0; lim[1] = 0;
        sink_ready = 1'b1;
        cap_q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic check_cap(input string tag, input logic [7:0] exp [$]);
        check({tag, "_len"}, 32'(cap_q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            check(tag, (k < cap_q.size()) ? 32'(cap_q[k]) : 32'h100, 32'(exp[k]));
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        req_valid  = 2'b11;
        req_data   = 16'hA511;
        src_ready  = 1'b1;
        sink_ready = 1'b1;
        cnt[0] = 0; cnt[1] = 0; lim[0] = 0; lim[1] = 0;
        repeat (2) @(negedge sys_clk);
        check("rst_valid", 32'(src_valid), 32'd0);
        check("rst_data",  32'(src_data),  32'h00);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id),  32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        sys_rst   = 1'b0;
        req_valid = 2'b00;

`ifndef SERIAL2TCP_ARB_TAG_EN
        // Single short burst from requester 0.
        lim[0] = 3;
        cycle();
        check("t1_busy",  32'(busy),      32'd1);
        check("t1_grant", 32'(grant_id),  32'd0);
        check("t1_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t1_valid", 32'(src_valid), 32'd1);
            check("t1_data",  32'(src_data),  32'(byte_of(0, k)));
        end
        cycle();
        check("t1_end_valid", 32'(src_valid), 32'd0);
        check("t1_end_busy",  32'(busy),      32'd0);
        check_cap("t1_seq", '{8'h11, 8'h22, 8'h33});

        // Both requesters always valid: alternating bursts of four.
        do_reset();
        lim[0] = 100; lim[1] = 100;
        for (int c = 1; c <= 15; c++) begin
            int phase;
            int grp;
            phase = (c - 1) % 5;
            grp   = (c - 1) / 5;
            cycle();
            if (phase == 0) begin
                check("t2_idle_valid", 32'(src_valid), 32'd0);
            end else begin
                check("t2_valid", 32'(src_valid), 32'd1);
                check("t2_data", 32'(src_data),
                      (grp == 1) ? 32'(byte_of(1, phase - 1)) : 32'(byte_of(0, (grp == 2 ? 4 : 0) + phase - 1)));
                if (phase == 1) check("t2_grant", 32'(grant_id), (grp == 1) ? 32'd1 : 32'd0);
            end
            if (phase == 4) check("t2_busy_low", 32'(busy), 32'd0);
        end

        // Sink stalls for five cycles while a byte is held.
        do_reset();
        lim[0] = 3;
        for (int c = 1; c <= 12; c++) begin
            sink_ready = !(c >= 3 && c <= 7);
            cycle();
            if (c >= 3 && c <= 7) begin
                check("t3_hold_valid", 32'(src_valid), 32'd1);
                check("t3_hold_data",  32'(src_data),  32'(byte_of(0, 0)));
                check("t3_hold_ready", 32'(req_ready), 32'd0);
            end
        end
        check("t3_busy", 32'(busy), 32'd0);
        check_cap("t3_seq", '{8'h11, 8'h22, 8'h33});

        // Reset pulse while a byte is held mid-burst.
        do_reset();
        lim[0] = 3;
        cycle();
        cycle();
        sink_ready = 1'b0;
        cycle();
        check("t4_pre_valid", 32'(src_valid), 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        check("t4_rst_valid", 32'(src_valid), 32'd0);
        check("t4_rst_busy",  32'(busy),      32'd0);
        check("t4_rst_ready", 32'(req_ready), 32'd0);
        check("t4_rst_grant", 32'(grant_id),  32'd1);
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        req_valid = 2'b00;
        cnt[0] = 0; cnt[1] = 0; lim[0] = 3; lim[1] = 3;
        sink_ready = 1'b1;
        cycle();
        check("t4_regrant", 32'(grant_id), 32'd0);
        check("t4_busy",    32'(busy),     32'd1);
`else
        // Tagged burst from requester 1.
        lim[1] = 1;
        cycle();
        check("tag_busy",  32'(busy),      32'd1);
        check("tag_grant", 32'(grant_id),  32'd1);
        check("tag_idle",  32'(src_valid), 32'd0);
        cycle();
        check("tag_valid", 32'(src_valid), 32'd1);
        check("tag_byte",  32'(src_data),  32'hF1);
        cycle();
        check("tag_data",  32'(src_data),  32'hAA);
        cycle();
        check("tag_end",   32'(src_valid), 32'd0);
        check("tag_endb",  32'(busy),      32'd0);
        check_cap("tag_seq", '{8'hF1, 8'hAA});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
